// File: rtl/rvw_pkg.sv
// Shared types and default widths for the ready/valid RAM writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rvw_pkg;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_ADDR_STEP  = 4;
   localparam int CNT_WIDTH      = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } rvw_state_t;

endpackage

// File: rtl/rv_skid_buffer.sv
// Two-entry skid buffer; the head entry drives the RAM write port directly.
// Latency: a pushed word is visible at the head on the next cycle when the buffer was empty.
// Backpressure: the caller only pushes when a slot is free (or one is freed the same cycle); pop ignored when empty.
module rv_skid_buffer #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_dat,
   input  logic                  i_pop,
   output logic                  o_vld,
   output logic [DATA_WIDTH-1:0] o_dat,
   output logic [1:0]            o_count
);

   logic [DATA_WIDTH-1:0] r_mem [0:1];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;
   logic                  w_push;
   logic                  w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   // When full, a simultaneous pop frees the slot being overwritten; the popped
   // value is read out before the edge replaces it.
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   // Storage, pointers and occupancy; reset empties the buffer and zeroes data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_vld   = (r_count != 2'd0);
   assign o_dat   = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/ready_valid_writer_with_wen.sv
// Streams NUM_WORDS upstream beats into RAM at BASE_ADDR + k*ADDR_STEP; optional WR_COUNT via RVW_WR_COUNT_EN.
// Latency: accepted beat drives WR_EN/WR_DATA one cycle later; DONE one cycle after the last commit.
// Backpressure: WR_STALL holds the write port stable; registered READY_OUT drops when the 2-entry skid buffer would fill.
module ready_valid_writer_with_wen
   import rvw_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ADDR_STEP  = DEF_ADDR_STEP
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  START,
   input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
   input  logic [CNT_WIDTH-1:0]  NUM_WORDS,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  VALID_IN,
   output logic                  READY_OUT,
   output logic                  WR_EN,
   output logic [ADDR_WIDTH-1:0] WR_ADDR,
   output logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  WR_STALL,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [CNT_WIDTH-1:0]  WR_COUNT
);

   rvw_state_t            r_state;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_done;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [CNT_WIDTH-1:0]  r_num;
   logic [CNT_WIDTH-1:0]  r_acc_cnt;
   logic [CNT_WIDTH-1:0]  r_cmt_cnt;

   logic                  w_accept;
   logic                  w_commit;
   logic                  w_head_vld;
   logic [DATA_WIDTH-1:0] w_head_dat;
   logic [1:0]            w_count;
   logic [1:0]            w_count_nxt;
   logic [CNT_WIDTH-1:0]  w_acc_nxt;
   logic                  w_last_acc;
   logic                  w_last_cmt;

   assign w_accept   = VALID_IN && r_ready && (r_state == RUN);
   assign w_commit   = w_head_vld && !WR_STALL;
   assign w_acc_nxt  = r_acc_cnt + (w_accept ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
   assign w_last_acc = w_accept && (r_acc_cnt == r_num - CNT_WIDTH'(1));
   assign w_last_cmt = w_commit && (r_cmt_cnt == r_num - CNT_WIDTH'(1));

   rv_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .i_clk      (CLK),
      .i_rst_n    (RSTN),
      .i_push     (w_accept),
      .i_push_dat (DATA_IN),
      .i_pop      (w_commit),
      .o_vld      (w_head_vld),
      .o_dat      (w_head_dat),
      .o_count    (w_count)
   );

   // Occupancy after this edge, used to decide next cycle's registered ready.
   always_comb begin
      w_count_nxt = w_count;
      if (w_accept && !w_commit) begin
         w_count_nxt = w_count + 2'd1;
      end else if (!w_accept && w_commit) begin
         w_count_nxt = w_count - 2'd1;
      end
   end

   // Transfer FSM with registered ready/busy/done and the head-of-buffer write address.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state   <= IDLE;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wr_addr <= '0;
         r_num     <= '0;
         r_acc_cnt <= '0;
         r_cmt_cnt <= '0;
      end else begin
         r_done <= 1'b0;
         // The address always belongs to the buffer head, so it advances only on commit.
         if (w_commit) begin
            r_cmt_cnt <= r_cmt_cnt + CNT_WIDTH'(1);
            r_wr_addr <= r_wr_addr + ADDR_WIDTH'(ADDR_STEP);
         end
         if (w_accept) begin
            r_acc_cnt <= w_acc_nxt;
         end
         case (r_state)
            IDLE: begin
               r_ready <= 1'b0;
               if (START) begin
                  if (NUM_WORDS == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state   <= RUN;
                     r_busy    <= 1'b1;
                     r_ready   <= 1'b1;
                     r_num     <= NUM_WORDS;
                     r_wr_addr <= BASE_ADDR;
                     r_acc_cnt <= '0;
                     r_cmt_cnt <= '0;
                  end
               end
            end
            RUN: begin
               if (w_last_acc) begin
                  r_state <= FLUSH;
                  r_ready <= 1'b0;
               end else begin
                  r_ready <= (w_count_nxt < 2'd2) && (w_acc_nxt < r_num);
               end
            end
            FLUSH: begin
               r_ready <= 1'b0;
               if (w_last_cmt) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RVW_WR_COUNT_EN
   logic [CNT_WIDTH-1:0] r_wr_count;

   // Free-running committed-write counter, cleared only by reset.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_wr_count <= '0;
      end else if (w_commit) begin
         r_wr_count <= r_wr_count + CNT_WIDTH'(1);
      end
   end

   assign WR_COUNT = r_wr_count;
`else
   assign WR_COUNT = '0;
`endif

   assign READY_OUT = r_ready;
   assign WR_EN     = w_head_vld;
   assign WR_ADDR   = r_wr_addr;
   assign WR_DATA   = w_head_dat;
   assign BUSY      = r_busy;
   assign DONE      = r_done;

endmodule

// File: tb/tb_ready_valid_writer_with_wen.sv
// Bench for ready_valid_writer_with_wen: vector table of transfers plus
// hand-written zero-length, reset and start-while-busy sequences; writes are
// checked against a scoreboard queue filled as beats are accepted upstream.
module tb_ready_valid_writer_with_wen;

   localparam int DW = 64;
   localparam int AW = 32;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          START;
   logic [AW-1:0] BASE_ADDR;
   logic [31:0]   NUM_WORDS;
   logic [DW-1:0] DATA_IN;
   logic          VALID_IN;
   logic          READY_OUT;
   logic          WR_EN;
   logic [AW-1:0] WR_ADDR;
   logic [DW-1:0] WR_DATA;
   logic          WR_STALL;
   logic          BUSY;
   logic          DONE;
   logic [31:0]   WR_COUNT;

   always #5 CLK = ~CLK;

   ready_valid_writer_with_wen #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .ADDR_STEP  (4)
   ) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .START     (START),
      .BASE_ADDR (BASE_ADDR),
      .NUM_WORDS (NUM_WORDS),
      .DATA_IN   (DATA_IN),
      .VALID_IN  (VALID_IN),
      .READY_OUT (READY_OUT),
      .WR_EN     (WR_EN),
      .WR_ADDR   (WR_ADDR),
      .WR_DATA   (WR_DATA),
      .WR_STALL  (WR_STALL),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .WR_COUNT  (WR_COUNT)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic [31:0] base;
      int          num;
      bit          stall;
      bit          vrand;
      logic [63:0] dhi;
      bit          poke;
      bit          tight;
      logic [31:0] exp_last;
   } vec_t;

   wr_t           sb[$];
   wr_t           sb_e;
   vec_t          vecs[6];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   int            nwr = 0;
   int            first_cyc, last_cyc, done_cyc, first_acc_cyc;
   bit            wr_en_seen = 0;
   logic [AW-1:0] last_addr = '0;
   bit            prev_hold = 0;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_data;
   bit            stall_on = 0;
   bit            stall_lvl = 0;
   int            stall_left = 0;
   logic [31:0]   exp_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Write-port monitor: scoreboard pop on each commit, stability under stall, DONE counting.
   always @(negedge CLK) begin
      if (RSTN) begin
         if (WR_EN) wr_en_seen = 1;
         if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (prev_hold) begin
            check("hold_wr_en", WR_EN, 1);
            check("hold_addr", WR_ADDR, prev_addr);
            check("hold_data", WR_DATA, prev_data);
         end
         if (WR_EN && !WR_STALL) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", WR_ADDR, WR_DATA);
            end else begin
               sb_e = sb.pop_front();
               check("wr_addr", WR_ADDR, sb_e.addr);
               check("wr_data", WR_DATA, sb_e.data);
            end
            if (nwr == 0) first_cyc = cyc;
            last_cyc  = cyc;
            last_addr = WR_ADDR;
            nwr++;
         end
         prev_hold = WR_EN && WR_STALL;
         prev_addr = WR_ADDR;
         prev_data = WR_DATA;
      end else begin
         prev_hold = 0;
      end
   end

   // Random RAM stall: alternating high bursts of 1..25 and low gaps of 1..8 cycles.
   initial begin
      WR_STALL = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (!stall_on) begin
            WR_STALL   = 1'b0;
            stall_left = 0;
         end else begin
            if (stall_left == 0) begin
               stall_lvl  = !stall_lvl;
               stall_left = stall_lvl ? $urandom_range(1, 25) : $urandom_range(1, 8);
            end
            WR_STALL = stall_lvl;
            stall_left--;
         end
      end
   end

   task automatic pulse_start(input logic [31:0] base, input logic [31:0] num);
      BASE_ADDR = base;
      NUM_WORDS = num;
      START     = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   task automatic feed(input vec_t v, input int limit);
      int  k = 0;
      int  guard = 0;
      bit  acc;
      wr_t w;
      while (k < limit) begin
         VALID_IN = v.vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
         DATA_IN  = v.dhi + 64'(k);
         if (v.poke && k == 3) begin
            START     = 1'b1;
            BASE_ADDR = 32'h900;
            NUM_WORDS = 32'd3;
         end else begin
            START = 1'b0;
         end
         @(negedge CLK);
         acc = VALID_IN && READY_OUT;
         if (acc && k == 0) first_acc_cyc = cyc;
         @(posedge CLK);
         #1;
         if (acc) begin
            w.addr = v.base + 32'(k) * 32'd4;
            w.data = v.dhi + 64'(k);
            sb.push_back(w);
            k++;
         end
         guard++;
         if (guard > 20000) begin
            total++;
            bad++;
            $display("FAIL feed_timeout: accepted %0d want %0d", k, limit);
            break;
         end
      end
      START    = 1'b0;
      VALID_IN = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int d0;
      int guard = 0;
      d0  = done_cnt;
      nwr = 0;
      pulse_start(v.base, 32'(v.num));
      check({tag, "_busy_start"}, BUSY, 1);
      stall_on = v.stall;
      feed(v, v.num);
      while (done_cnt == d0 && guard < 5000) begin
         @(posedge CLK);
         #1;
         guard++;
      end
      stall_on = 0;
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      check({tag, "_done_pulses"}, done_cnt - d0, 1);
      check({tag, "_writes"}, nwr, v.num);
      check({tag, "_sb_left"}, sb.size(), 0);
      check({tag, "_last_addr"}, last_addr, v.exp_last);
      check({tag, "_busy_end"}, BUSY, 0);
      exp_cnt += 32'(v.num);
`ifdef RVW_WR_COUNT_EN
      check({tag, "_wr_count"}, WR_COUNT, exp_cnt);
`else
      check({tag, "_wr_count"}, WR_COUNT, 32'd0);
`endif
      if (v.tight) begin
         check({tag, "_back_to_back"}, last_cyc - first_cyc, v.num - 1);
         check({tag, "_done_after_last"}, done_cyc - last_cyc, 1);
         check({tag, "_first_latency"}, first_cyc - first_acc_cyc, 1);
      end
   endtask

   initial begin
      vec_t r;
      int   d0;
      vecs[0] = '{32'h0000_0100, 4,    1'b0, 1'b0, 64'hA000_0000_0000_0000, 1'b0, 1'b1, 32'h0000_010C};
      vecs[1] = '{32'hFFFF_FFF8, 4,    1'b0, 1'b0, 64'hB000_0000_0000_0000, 1'b0, 1'b1, 32'h0000_0004};
      vecs[2] = '{32'h0000_2000, 1,    1'b0, 1'b0, 64'hC000_0000_0000_0000, 1'b0, 1'b1, 32'h0000_2000};
      vecs[3] = '{32'h0000_0040, 17,   1'b1, 1'b1, 64'hD000_0000_0000_0000, 1'b0, 1'b0, 32'h0000_0080};
      vecs[4] = '{32'h0000_0000, 1000, 1'b1, 1'b0, 64'h0,                   1'b0, 1'b0, 32'h0000_0F9C};
      vecs[5] = '{32'h0000_0300, 8,    1'b0, 1'b0, 64'hE000_0000_0000_0000, 1'b1, 1'b1, 32'h0000_031C};

      RSTN      = 1'b0;
      START     = 1'b0;
      BASE_ADDR = '0;
      NUM_WORDS = '0;
      DATA_IN   = '0;
      VALID_IN  = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_ready", READY_OUT, 0);
      check("rst_wr_en", WR_EN, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_wr_addr", WR_ADDR, 0);
      check("rst_wr_data", WR_DATA, 0);
      check("rst_wr_count", WR_COUNT, 0);
      @(posedge CLK);
      #1;
      RSTN = 1'b1;
      repeat (2) begin
         @(posedge CLK);
         #1;
      end

      // Zero-length transfer: DONE next cycle, nothing written, never busy.
      d0         = done_cnt;
      wr_en_seen = 0;
      pulse_start(32'h40, 32'd0);
      @(negedge CLK);
      check("zero_done", DONE, 1);
      check("zero_busy", BUSY, 0);
      check("zero_ready", READY_OUT, 0);
      @(negedge CLK);
      check("zero_done_drop", DONE, 0);
      repeat (3) @(negedge CLK);
      check("zero_no_wr", wr_en_seen, 0);
      check("zero_done_pulses", done_cnt - d0, 1);
      @(posedge CLK);
      #1;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset after 10 of 20 accepted words: outputs clear at once, nothing afterwards.
      r = '{32'h0000_0500, 20, 1'b0, 1'b0, 64'h7700_0000_0000_0000, 1'b0, 1'b0, 32'h0};
      pulse_start(r.base, 32'(r.num));
      feed(r, 10);
      VALID_IN = 1'b1;
      RSTN     = 1'b0;
      #1;
      check("arst_ready", READY_OUT, 0);
      check("arst_wr_en", WR_EN, 0);
      check("arst_busy", BUSY, 0);
      check("arst_done", DONE, 0);
      check("arst_wr_addr", WR_ADDR, 0);
      check("arst_wr_data", WR_DATA, 0);
      check("arst_wr_count", WR_COUNT, 0);
      sb.delete();
      exp_cnt = 0;
      @(posedge CLK);
      #1;
      RSTN       = 1'b1;
      wr_en_seen = 0;
      repeat (20) begin
         @(posedge CLK);
         #1;
      end
      check("post_rst_no_wr", wr_en_seen, 0);
      check("post_rst_ready", READY_OUT, 0);
      VALID_IN = 1'b0;

      r = '{32'h0000_0010, 2, 1'b0, 1'b0, 64'h5500_0000_0000_0000, 1'b0, 1'b1, 32'h0000_0014};
      run_vec(r, "recover");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
